prog_loader: RTL

Serial program loader that writes 24-bit instruction words into the CPU program memory, on the write side of the port the ROM fetch path reads. It accepts a framed byte stream from a byte receiver (UART RX) over a valid/ready handshake. It assembles three bytes per instruction, issues one memory write per word, and holds the CPU core in reset while a load is in flight. It sits beside `rom` in `top`: its write port feeds program memory, and `cpu_hold` is ORed into the core reset.

---
 rtl/prog_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: serial program loader. Assembles framed bytes (A5, N, N*3 payload,
// checksum) into 24-bit words and writes them into program memory, holding the CPU
// in reset until a good frame completes.
// Ports: clk/rst (async active-high); rx_valid/rx_ready/rx_data byte input;
//        mem_w_enable/mem_w_addr/mem_w_data write port; cpu_hold, done, error, busy status.
module prog_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_w_enable,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [23:0]           mem_w_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

  state_t                state, state_nx;
  logic                  accept;
  logic                  timeout;
  logic                  last_word;
  logic [7:0]            n;          // word count, 0 encodes 256
  logic [7:0]            wcnt;       // words issued so far
  logic [7:0]            sum;
  logic [7:0]            check_sum;
  logic [15:0]           word;       // first two bytes of the word being assembled
  logic [1:0]            bidx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TW-1:0]         idle_cnt;

  // The write strobe cycle is the only cycle in which a byte cannot be taken.
  assign rx_ready  = !mem_w_enable;
  assign accept    = rx_valid && rx_ready;
  assign busy      = (state != IDLE);
  assign timeout   = busy && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES));
  // n - 1 wraps to 0xFF for n = 0, which gives the 256-word case for free.
  assign last_word = (wcnt == n - 8'd1);
  assign check_sum = sum + rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    if (rx_data == SYNC) state_nx = COUNT;
        COUNT:   state_nx = DATA;
        DATA:    if (bidx == 2'd2 && last_word) state_nx = CHECK;
        CHECK:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_w_enable <= 1'b0;
      mem_w_addr   <= '0;
      mem_w_data   <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      n            <= '0;
      wcnt         <= '0;
      sum          <= '0;
      word         <= '0;
      bidx         <= '0;
      addr         <= '0;
      idle_cnt     <= '0;
    end else begin
      mem_w_enable <= 1'b0;
      done         <= 1'b0;

      // Idle counter only runs while a frame is open and no byte arrives.
      if (accept || !busy || timeout) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + TW'(1);

      if (timeout) begin
        error <= 1'b1;
      end else if (accept) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC) begin
              cpu_hold <= 1'b1;
              error    <= 1'b0;
            end
          end
          COUNT: begin
            n    <= rx_data;
            wcnt <= '0;
            addr <= '0;
            bidx <= '0;
            sum  <= '0;
          end
          DATA: begin
            sum  <= check_sum;
            word <= {word[7:0], rx_data};
            if (bidx == 2'd2) begin
              mem_w_enable <= 1'b1;
              mem_w_addr   <= addr;
              mem_w_data   <= {word, rx_data};
              addr         <= addr + ADDR_WIDTH'(1);
              wcnt         <= wcnt + 8'd1;
              bidx         <= '0;
            end else begin
              bidx <= bidx + 2'd1;
            end
          end
          CHECK: begin
            done <= 1'b1;
            if (check_sum == 8'h00) cpu_hold <= 1'b0;
            else                    error    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
